// File: rtl/max7219_apb_ctrl_if.sv
// APB3 bus bundle between a CPU-side master and the MAX7219 controller.
// Ports: psel/penable/pwrite/paddr/pwdata from the master; prdata/pready/pslverr back.
// No clock inside: the bus is sampled by the slave's own clk.
interface max7219_apb_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/max7219_apb_ctrl.sv
// APB slave feeding a MAX7219 driver: holds the displayed value, optional binary->BCD
// (double-dabble, data_vector updates 29 cycles after the write; raw/error 1 cycle).
// Zero-wait APB (pready=1). Ports: clk, reset_n, apb (slave), clkdiv tick, data_vector.
module max7219_apb_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] DIV_RESET = 16'd99,
  parameter logic        BCD_RESET = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  max7219_apb_ctrl_if.slave        apb,
  output logic                     clkdiv,
  output logic [31:0]              data_vector
);

  localparam logic [31:0] BCD_MAX = 32'd99_999_999;
  localparam logic [31:0] ERR_PAT = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] paddr_w;
  logic              unused_paddr_hi;
  logic [1:0]        ofs;
  logic              acc;
  logic              misaligned;
  logic              wr_ok;
  logic              wr_data;
  logic              wr_ctrl;
  logic              wr_div;
  logic              upd_trig;
  logic [31:0]       rd_dat;

  assign paddr_w         = apb.paddr;
  assign unused_paddr_hi = ^paddr_w[ADDR_W-1:4];
  assign ofs             = paddr_w[3:2];
  assign acc             = apb.psel & apb.penable;
  assign misaligned      = |paddr_w[1:0];
  assign wr_ok           = acc & apb.pwrite & ~misaligned;
  assign wr_data         = wr_ok & (ofs == 2'd0);
  assign wr_ctrl         = wr_ok & (ofs == 2'd1);
  assign wr_div          = wr_ok & (ofs == 2'd2);
  assign upd_trig        = wr_data | wr_ctrl;

  // Architectural registers
  logic [31:0] data_q;
  logic        bcd_en_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic        clkdiv_q;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  // Set on the write edge so the engine acts on the already-updated DATA/CTRL
  logic        start_q;

  // Conversion engine state
  state_t      state_q, state_d;
  logic [58:0] shreg_q, shreg_d;   // {bcd[31:0], bin[26:0]}
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        busy_q, busy_d;
  logic [31:0] dv_q, dv_d;

  always_comb begin
    rd_dat = 32'd0;
    case (ofs)
      2'd0: rd_dat = data_q;
      2'd1: rd_dat = {31'd0, bcd_en_q};
      2'd2: rd_dat = {16'd0, div_q};
      2'd3: rd_dat = {31'd0, busy_q};
      default: rd_dat = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= 32'd0;
      bcd_en_q  <= BCD_RESET;
      div_q     <= DIV_RESET;
      cnt_q     <= DIV_RESET;
      clkdiv_q  <= 1'b0;
      prdata_q  <= 32'd0;
      pslverr_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= upd_trig;

      if (acc) begin
        prdata_q  <= (apb.pwrite | misaligned) ? 32'd0 : rd_dat;
        pslverr_q <= misaligned;
      end

      if (wr_data) data_q   <= apb.pwdata;
      if (wr_ctrl) bcd_en_q <= apb.pwdata[0];
      if (wr_div)  div_q    <= apb.pwdata[15:0];

      // A DIV write restarts the tick period immediately from the new value
      if (wr_div) begin
        cnt_q    <= apb.pwdata[15:0];
        clkdiv_q <= 1'b0;
      end else if (cnt_q == 16'd0) begin
        cnt_q    <= div_q;
        clkdiv_q <= 1'b1;
      end else begin
        cnt_q    <= cnt_q - 16'd1;
        clkdiv_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double-dabble step: adjust every BCD nibble >= 5 by +3, then shift left.
  // ---------------------------------------------------------------------------
  function automatic logic [58:0] dd_step(input logic [58:0] s);
    logic [58:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      if (t[27 + 4*i +: 4] >= 4'd5) begin
        t[27 + 4*i +: 4] = t[27 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[57:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= 59'd0;
      bitcnt_q <= 5'd0;
      busy_q   <= 1'b0;
      dv_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      dv_q     <= dv_d;
    end
  end

  // A pending start has priority over whatever the engine is doing, which is how
  // a new write aborts a running conversion. dv only changes on a start (raw or
  // error pattern) or in DONE, so no partial result is ever visible.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    dv_d     = dv_q;

    if (start_q) begin
      if (!bcd_en_q) begin
        dv_d    = data_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else if (data_q > BCD_MAX) begin
        dv_d    = ERR_PAT;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        shreg_d  = {32'd0, data_q[26:0]};
        bitcnt_d = 5'd27;
        busy_d   = 1'b1;
        state_d  = ST_SHIFT;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          shreg_d  = dd_step(shreg_q);
          bitcnt_d = bitcnt_q - 5'd1;
          if (bitcnt_q == 5'd1) state_d = ST_DONE;
        end
        ST_DONE: begin
          dv_d    = shreg_q[58:27];
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = pslverr_q;
  assign clkdiv      = clkdiv_q;
  assign data_vector = dv_q;

endmodule

// File: tb/tb_max7219_apb_ctrl.sv
// Self-checking bench for max7219_apb_ctrl: random DATA/CTRL traffic against a
// decimal-arithmetic reference, plus divider, error-response and async-reset checks.
// Drives APB through the interface master side; samples #1 after each rising edge.
module tb_max7219_apb_ctrl;

  localparam logic [15:0] A_DATA = 16'h0000;
  localparam logic [15:0] A_CTRL = 16'h0004;
  localparam logic [15:0] A_DIV  = 16'h0008;
  localparam logic [15:0] A_STAT = 16'h000C;

  logic        clk;
  logic        reset_n;
  logic        clkdiv;
  logic [31:0] data_vector;

  max7219_apb_ctrl_if #(.ADDR_W(16)) apb ();

  max7219_apb_ctrl #(
    .ADDR_W    (16),
    .DIV_RESET (16'd99),
    .BCD_RESET (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .apb         (apb),
    .clkdiv      (clkdiv),
    .data_vector (data_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference-model view of the programmed registers
  logic [31:0] m_data;
  logic        m_bcd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // What the display should show for a given DATA / bcd_en pair
  function automatic logic [31:0] ref_dv(input logic [31:0] d, input logic en);
    logic [31:0]  r;
    int unsigned  v;
    if (!en) return d;
    if (d > 32'd99_999_999) return 32'hEEEE_EEEE;
    r = 32'd0;
    v = d;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit is_conv(input logic [31:0] d, input logic en);
    return en && (d <= 32'd99_999_999);
  endfunction

  // One APB transfer (setup + access); returns after the access edge, at +1
  task automatic apb_xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    @(negedge clk);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = w;
    apb.paddr   = a;
    apb.pwdata  = d;
    @(negedge clk);
    apb.penable = 1'b1;
    @(posedge clk);
    #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    rd  = apb.prdata;
    err = apb.pslverr;
  endtask

  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, a, d, rd, err);
  endtask

  task automatic apb_rd(input logic [15:0] a, output logic [31:0] rd);
    logic err;
    apb_xfer(1'b0, a, 32'd0, rd, err);
  endtask

  // Called right after an update-triggering write edge. Polls STATUS every cycle
  // (continuous access phase) and watches data_vector for its first change.
  task automatic track(input string tag, input logic [31:0] exp, input int lat, input int busy_exp);
    logic [31:0] old_dv;
    int          first;
    int          busy_n;
    logic        glitch;
    old_dv = data_vector;
    first  = 0;
    busy_n = 0;
    glitch = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b0;
    apb.paddr   = A_STAT;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (apb.prdata[0]) busy_n++;
      if (first == 0 && data_vector !== old_dv) first = k;
      if (data_vector !== old_dv && data_vector !== exp) glitch = 1'b1;
    end
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    check({tag, "_dv"}, data_vector, exp);
    check({tag, "_lat"}, first, (exp === old_dv) ? 0 : lat);
    check({tag, "_busy"}, busy_n, busy_exp);
    check({tag, "_partial"}, {31'd0, glitch}, 32'd0);
  endtask

  task automatic write_and_track(input string tag, input logic [15:0] a, input logic [31:0] d);
    apb_wr(a, d);
    if (a == A_DATA) m_data = d;
    else             m_bcd  = d[0];
    track(tag, ref_dv(m_data, m_bcd),
          is_conv(m_data, m_bcd) ? 29 : 1,
          is_conv(m_data, m_bcd) ? 28 : 0);
  endtask

  // Finds the first two clkdiv pulses within a bounded window
  task automatic measure_clkdiv(output int first, output int period);
    int second;
    first  = -1;
    second = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (clkdiv) begin
        if (first < 0)       first = k;
        else if (second < 0) second = k;
      end
      if (second >= 0) break;
    end
    period = (first >= 0 && second >= 0) ? second - first : -1;
  endtask

  task automatic div_test(input string tag, input logic [15:0] v);
    int f;
    int p;
    apb_wr(A_DIV, {16'hA5A5, v});
    check({tag, "_deassert"}, {31'd0, clkdiv}, 32'd0);
    measure_clkdiv(f, p);
    check({tag, "_first"}, f, int'(v) + 1);
    check({tag, "_period"}, p, int'(v) + 1);
  endtask

  function automatic logic [31:0] gen_data();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom_range(0, 99_999_999);
      1: r = $urandom;
      2: r = 32'd99_999_999 + ($urandom_range(0, 2));
      default: r = $urandom_range(0, 999);
    endcase
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] r;
    logic [31:0] old_dv;
    logic        stable;
    int          f;
    int          p;

    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    reset_n     = 1'b0;
    m_data      = 32'd0;
    m_bcd       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dv", data_vector, 32'd0);
    check("rst_clkdiv", {31'd0, clkdiv}, 32'd0);
    check("rst_prdata", apb.prdata, 32'd0);
    check("rst_pslverr", {31'd0, apb.pslverr}, 32'd0);
    check("pready", {31'd0, apb.pready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset register contents and default tick period
    apb_rd(A_DIV, rd);  check("rst_div", rd, 32'h63);
    apb_rd(A_CTRL, rd); check("rst_ctrl", rd, 32'h0);
    apb_rd(A_STAT, rd); check("rst_stat", rd, 32'h0);
    apb_rd(A_DATA, rd); check("rst_data", rd, 32'h0);
    measure_clkdiv(f, p);
    check("rst_period", p, 100);

    // Raw mode
    write_and_track("raw", A_DATA, 32'h1234_ABCD);
    apb_rd(A_DATA, rd); check("raw_rb", rd, 32'h1234_ABCD);

    // BCD mode: enabling with an out-of-range value gives the error pattern
    write_and_track("en_bcd", A_CTRL, 32'h1);
    write_and_track("bcd12345678", A_DATA, 32'h00BC_614E);
    write_and_track("over", A_DATA, 32'd100_000_000);
    write_and_track("max", A_DATA, 32'd99_999_999);

    // Abort: second write while the first conversion is running
    apb_wr(A_DATA, 32'd42);
    m_data = 32'd42;
    old_dv = data_vector;
    stable = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (data_vector !== old_dv) stable = 1'b0;
    end
    check("abort_hold", {31'd0, stable}, 32'd1);
    apb_wr(A_DATA, 32'd7);
    m_data = 32'd7;
    track("abort", 32'h0000_0007, 29, 29);

    // Randomized traffic against the reference model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        write_and_track("rnd_ctrl", A_CTRL, r);
      end else begin
        write_and_track("rnd_data", A_DATA, gen_data());
      end
      if (m_bcd && (it % 6 == 5)) begin
        apb_wr(A_DATA, $urandom_range(0, 99_999_999));
        old_dv = data_vector;
        stable = 1'b1;
        repeat ($urandom_range(1, 20)) begin
          @(posedge clk);
          #1;
          if (data_vector !== old_dv) stable = 1'b0;
        end
        check("rnd_abort_hold", {31'd0, stable}, 32'd1);
        m_data = $urandom_range(0, 99_999_999);
        apb_wr(A_DATA, m_data);
        track("rnd_abort", ref_dv(m_data, 1'b1), 29, 29);
      end
    end
    apb_rd(A_CTRL, rd); check("rnd_ctrl_rb", rd, {31'd0, m_bcd});
    apb_rd(A_DATA, rd); check("rnd_data_rb", rd, m_data);

    // Divider
    div_test("div0", 16'd0);
    div_test("div3", 16'd3);
    for (int i = 0; i < 3; i++) div_test("div_rnd", 16'($urandom_range(1, 30)));
    apb_rd(A_DIV, rd);    r = rd;
    check("div_rb_hi0", {16'd0, r[31:16]}, 32'd0);
    apb_rd(16'hFFF8, rd); check("addr_hi_ignored", rd, r);

    // Error response and ignored writes
    old_dv = data_vector;
    apb_xfer(1'b1, 16'h0002, 32'hDEAD_BEEF, rd, err);
    check("mis_wr_err", {31'd0, err}, 32'd1);
    apb_xfer(1'b0, 16'h0005, 32'd0, rd, err);
    check("mis_rd_err", {31'd0, err}, 32'd1);
    check("mis_rd_dat", rd, 32'd0);
    apb_rd(A_DATA, rd);   check("mis_no_write", rd, m_data);
    check("mis_no_update", data_vector, old_dv);
    apb_xfer(1'b1, A_STAT, 32'hFFFF_FFFF, rd, err);
    check("stat_wr_err", {31'd0, err}, 32'd0);
    apb_rd(A_STAT, rd);   check("stat_ro", rd, 32'd0);

    // Asynchronous reset in the middle of a conversion
    if (!m_bcd) apb_wr(A_CTRL, 32'h1);
    repeat (35) @(posedge clk);
    apb_wr(A_DATA, 32'd87_654_321);
    repeat (5) @(posedge clk);
    apb_rd(A_STAT, rd);   check("mid_busy", rd, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_dv", data_vector, 32'd0);
    check("arst_prdata", apb.prdata, 32'd0);
    check("arst_clkdiv", {31'd0, clkdiv}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_data = 32'd0;
    m_bcd  = 1'b0;
    apb_rd(A_STAT, rd);   check("arst_stat", rd, 32'd0);
    apb_rd(A_DATA, rd);   check("arst_data", rd, 32'd0);
    apb_rd(A_DIV, rd);    check("arst_div", rd, 32'h63);
    repeat (35) @(posedge clk);
    #1;
    check("arst_dv_stays", data_vector, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
